// File: rtl/mant_norm_round24.sv
// Two-stage normalize and round-to-nearest-even for the 24-bit multiplier product, valid/ready on both sides.
// Optional exponent saturation with underflow/overflow flags: define MANT_NORM_SAT_EN.
module mant_norm_round24 #(
    parameter int INWRDLEN  = 24,
    parameter int OPWRDLEN  = 16,
    parameter int EXPWRDLEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INWRDLEN-1:0]  in_mant,
    input  logic [EXPWRDLEN-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPWRDLEN-1:0]  out_mant,
    output logic [EXPWRDLEN-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_unf,
    output logic                 out_ovf
);
    localparam int LZW    = $clog2(INWRDLEN + 1);
    localparam int GRDBIT = INWRDLEN - OPWRDLEN - 1;

    logic                 r_s1Valid;
    logic [INWRDLEN-1:0]  r_s1Norm;
    logic [LZW-1:0]       r_s1Lz;
    logic [EXPWRDLEN-1:0] r_s1Exp;
    logic                 r_s1Zero;

    logic                 r_s2Valid;
    logic [OPWRDLEN-1:0]  r_outMant;
    logic [EXPWRDLEN-1:0] r_outExp;
    logic                 r_outZero;

    logic                 w_s2Load;
    logic                 w_accept;
    logic [LZW-1:0]       w_lz;
    logic [OPWRDLEN-1:0]  w_top;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_roundUp;
    logic [OPWRDLEN:0]    w_sum;
    logic                 w_carry;
    logic [OPWRDLEN-1:0]  w_rndMant;
    logic [OPWRDLEN-1:0]  w_mant;
    logic [EXPWRDLEN-1:0] w_exp;

    assign w_s2Load = !r_s2Valid || out_ready;
    assign in_ready = !r_s1Valid || w_s2Load;
    assign w_accept = in_valid && in_ready;

    // The highest set bit is scanned last, so it wins; an all-zero input keeps lz = INWRDLEN.
    always_comb begin
        w_lz = LZW'(INWRDLEN);
        for (int i = 0; i < INWRDLEN; i++) begin
            if (in_mant[i]) w_lz = LZW'(INWRDLEN - 1 - i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Norm  <= '0;
            r_s1Lz    <= '0;
            r_s1Exp   <= '0;
            r_s1Zero  <= 1'b0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Norm  <= in_mant << w_lz;
            r_s1Lz    <= w_lz;
            r_s1Exp   <= in_exp;
            r_s1Zero  <= (in_mant == '0);
        end else if (w_s2Load) begin
            r_s1Valid <= 1'b0;
        end
    end

    assign w_top     = r_s1Norm[INWRDLEN-1 -: OPWRDLEN];
    assign w_guard   = r_s1Norm[GRDBIT];
    assign w_sticky  = |r_s1Norm[GRDBIT-1:0];
    assign w_roundUp = w_guard && (w_sticky || w_top[0]);
    assign w_sum     = {1'b0, w_top} + {{OPWRDLEN{1'b0}}, w_roundUp};
    assign w_carry   = w_sum[OPWRDLEN];
    // A carry out means the mantissa rolled to 1.000..., which renormalizes to the MSB alone.
    assign w_rndMant = w_carry ? {1'b1, {(OPWRDLEN-1){1'b0}}} : w_sum[OPWRDLEN-1:0];

`ifdef MANT_NORM_SAT_EN
    logic [EXPWRDLEN+1:0] w_eWide;
    logic                 w_unf;
    logic                 w_ovf;
    logic                 r_outUnf;
    logic                 r_outOvf;

    // Two extra bits: the top one is the sign (underflow), the next one flags e above the exponent range.
    assign w_eWide = {2'b00, r_s1Exp}
                   - {{(EXPWRDLEN+2-LZW){1'b0}}, r_s1Lz}
                   + {{(EXPWRDLEN+1){1'b0}}, w_carry};
    assign w_unf = w_eWide[EXPWRDLEN+1];
    assign w_ovf = !w_unf && w_eWide[EXPWRDLEN];

    always_comb begin
        w_mant = w_rndMant;
        w_exp  = w_eWide[EXPWRDLEN-1:0];
        if (w_unf) begin
            w_mant = '0;
            w_exp  = '0;
        end else if (w_ovf) begin
            w_mant = {1'b1, {(OPWRDLEN-1){1'b0}}};
            w_exp  = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outUnf <= 1'b0;
            r_outOvf <= 1'b0;
        end else if (w_s2Load && r_s1Valid) begin
            r_outUnf <= !r_s1Zero && w_unf;
            r_outOvf <= !r_s1Zero && w_ovf;
        end
    end

    assign out_unf = r_outUnf;
    assign out_ovf = r_outOvf;
`else
    assign w_mant  = w_rndMant;
    assign w_exp   = r_s1Exp - EXPWRDLEN'(r_s1Lz) + EXPWRDLEN'(w_carry);
    assign out_unf = 1'b0;
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_outMant <= '0;
            r_outExp  <= '0;
            r_outZero <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outZero <= r_s1Zero;
                r_outMant <= r_s1Zero ? '0 : w_mant;
                r_outExp  <= r_s1Zero ? '0 : w_exp;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign out_mant  = r_outMant;
    assign out_exp   = r_outExp;
    assign out_zero  = r_outZero;
endmodule

// File: tb/tb_mant_norm_round24.sv
// Self-checking bench for mant_norm_round24: directed vector table, backpressure and reset sequences,
// and randomized traffic scored against an arithmetic reference model. Honours MANT_NORM_SAT_EN.
module tb_mant_norm_round24;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_unf;
    logic        out_ovf;

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        unf;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [23:0] inMant;
        logic [7:0]  inExp;
        res_t        want;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    res_t expQ[$];

    mant_norm_round24 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_unf   (out_unf),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: locate the leading one, then round on the dropped byte by integer comparison with one half.
    function automatic res_t refModel(input logic [23:0] m, input logic [7:0] x);
        res_t        r;
        int          msb;
        int          lz;
        int          e;
        int          carry;
        int unsigned norm;
        int unsigned top;
        int unsigned rem;
        r = '{mant: 16'h0, exp: 8'h0, zero: 1'b0, unf: 1'b0, ovf: 1'b0};
        if (m == 24'h0) begin
            r.zero = 1'b1;
            return r;
        end
        msb = 23;
        while (m[msb] == 1'b0) msb--;
        lz    = 23 - msb;
        norm  = int'(m) << lz;
        top   = norm / 256;
        rem   = norm % 256;
        if (rem > 128 || (rem == 128 && (top % 2) == 1)) top++;
        carry = (top == 65536) ? 1 : 0;
        if (carry == 1) top = 32768;
        e = int'(x) - lz + carry;
`ifdef MANT_NORM_SAT_EN
        if (e < 0) begin
            r.unf = 1'b1;
        end else if (e > 255) begin
            r.mant = 16'h8000;
            r.exp  = 8'hFF;
            r.ovf  = 1'b1;
        end else begin
            r.mant = 16'(top);
            r.exp  = 8'(e);
        end
`else
        r.mant = 16'(top);
        r.exp  = 8'(e & 255);
`endif
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input res_t want);
        checks++;
        if (out_mant !== want.mant || out_exp !== want.exp || out_zero !== want.zero ||
            out_unf !== want.unf || out_ovf !== want.ovf) begin
            errors++;
            $display("[TB] FAIL %s: got mant=%h exp=%0d zero=%b unf=%b ovf=%b, expected mant=%h exp=%0d zero=%b unf=%b ovf=%b",
                     name, out_mant, out_exp, out_zero, out_unf, out_ovf,
                     want.mant, want.exp, want.zero, want.unf, want.ovf);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] m, input logic [7:0] x);
        in_valid = v;
        in_mant  = m;
        in_exp   = x;
    endtask

    task automatic stepCycle(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat queues its model result, every drained beat is compared in order.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got beat mant=%h exp=%0d, expected no beat", out_mant, out_exp);
                end else begin
                    checkOutput("sb_order", expQ.pop_front());
                end
            end
            if (in_valid && in_ready) expQ.push_back(refModel(in_mant, in_exp));
        end
    end

    initial begin
        vec_t        vecs[12];
        logic [23:0] bpMant[6];
        bit          acc;
        int          idx;
        logic [23:0] m;

        vecs[0]  = '{24'h800000, 8'd100, '{16'h8000, 8'd100, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{24'h000001, 8'd50,  '{16'h8000, 8'd27,  1'b0, 1'b0, 1'b0}};
        vecs[2]  = '{24'hFFFF80, 8'd10,  '{16'h8000, 8'd11,  1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{24'h800080, 8'd20,  '{16'h8000, 8'd20,  1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{24'h800180, 8'd20,  '{16'h8002, 8'd20,  1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{24'h800081, 8'd20,  '{16'h8001, 8'd20,  1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{24'h000000, 8'd77,  '{16'h0000, 8'd0,   1'b1, 1'b0, 1'b0}};
        vecs[7]  = '{24'h7FFFFF, 8'd5,   '{16'h8000, 8'd5,   1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{24'h123456, 8'd40,  '{16'h91A3, 8'd37,  1'b0, 1'b0, 1'b0}};
`ifdef MANT_NORM_SAT_EN
        vecs[9]  = '{24'h000100, 8'd10,  '{16'h0000, 8'd0,   1'b0, 1'b1, 1'b0}};
        vecs[10] = '{24'hFFFF80, 8'd255, '{16'h8000, 8'd255, 1'b0, 1'b0, 1'b1}};
        vecs[11] = '{24'h000180, 8'd0,   '{16'h0000, 8'd0,   1'b0, 1'b1, 1'b0}};
`else
        vecs[9]  = '{24'h000100, 8'd10,  '{16'h8000, 8'd251, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{24'hFFFF80, 8'd255, '{16'h8000, 8'd0,   1'b0, 1'b0, 1'b0}};
        vecs[11] = '{24'h000180, 8'd0,   '{16'hC000, 8'd241, 1'b0, 1'b0, 1'b0}};
`endif
        bpMant = '{24'h800000, 24'h400001, 24'h0F0F0F, 24'hFFFF80, 24'h000003, 24'h800180};

        rst = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 24'h0, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_outputs", '{16'h0, 8'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].inMant, vecs[i].inExp);
            stepCycle(acc);
            checkVal($sformatf("vec%0d_accept", i), 32'(acc), 32'd1);
            applyStimulus(1'b0, 24'h0, 8'h0);
            @(negedge clk);
            checkVal($sformatf("vec%0d_lat_early", i), 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkVal($sformatf("vec%0d_lat_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_data", i), vecs[i].want);
            @(posedge clk);
            #1;
        end

        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, bpMant[idx], 8'(60 + idx));
            stepCycle(acc);
            if (acc) idx++;
        end
        checkVal("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        checkVal("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (idx < 6) applyStimulus(1'b1, bpMant[idx], 8'(60 + idx));
            else         applyStimulus(1'b0, 24'h0, 8'h0);
            @(negedge clk);
            checkVal($sformatf("bp_rate%0d", c), 32'(out_valid), 32'd1);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 24'h0, 8'h0);
        checkVal("bp_all_accepted", 32'(idx), 32'd6);
        @(negedge clk);
        checkVal("bp_drained", 32'(out_valid), 32'd0);
        checkVal("bp_queue_empty", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset with both stages full");
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 24'h00ABCD + 24'(c), 8'd90);
            stepCycle(acc);
        end
        applyStimulus(1'b0, 24'h0, 8'h0);
        @(negedge clk);
        checkVal("rstmid_full_valid", 32'(out_valid), 32'd1);
        checkVal("rstmid_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkVal("rstmid_valid", 32'(out_valid), 32'd0);
        checkVal("rstmid_ready", 32'(in_ready), 32'd1);
        checkOutput("rstmid_outputs", '{16'h0, 8'h0, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkVal($sformatf("rstmid_nostale%0d", c), 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        acc = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (!in_valid || acc) begin
                m = 24'($urandom);
                m = m >> $urandom_range(0, 24);
                if ($urandom_range(0, 5) == 0) m[7:0] = 8'h80;
                if ($urandom_range(0, 15) == 0) m = 24'h0;
                applyStimulus(($urandom_range(0, 3) != 0), m, 8'($urandom));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            stepCycle(acc);
        end
        applyStimulus(1'b0, 24'h0, 8'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        checkVal("rand_drain_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mant_norm_round24.md
Name: mant_norm_round24

Overview:
- Pipelined normalize-and-round stage that sits directly downstream of the 16x32 mantissa multiplier.
- Consumes the multiplier's 24-bit truncated product plus a biased exponent.
- Left-normalizes on the leading one, adjusts the exponent, and rounds to a 16-bit mantissa (round-to-nearest-even).
- Presents the result on a valid/ready interface with full backpressure.

Parameters:
- INWRDLEN, 24, input mantissa width (fixed by the upstream product slice).
- OPWRDLEN, 16, output mantissa width; must be < INWRDLEN.
- EXPWRDLEN, 8, unsigned biased exponent width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_mant  input  INWRDLEN  product mantissa, unnormalized.
- in_exp  input  EXPWRDLEN  biased exponent accompanying in_mant.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_mant  output  OPWRDLEN  normalized, rounded mantissa; MSB = 1 unless zero.
- out_exp  output  EXPWRDLEN  adjusted exponent.
- out_zero  output  1  input mantissa was zero.
- out_unf  output  1  exponent underflow (see Optional Feature).
- out_ovf  output  1  exponent overflow (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high, fixed. With rst high at a clock edge:
  - both stage-valid flags clear;
  - out_valid=0, out_mant=0, out_exp=0, out_zero=0, out_unf=0, out_ovf=0;
  - in_ready=1 from the next cycle.
- Reset mid-operation discards all in-flight beats. No partial output is ever emitted.
- Handshake:
  - A beat transfers on a clock edge with valid & ready.
  - Data and valid stay stable while valid=1 and ready=0.
  - out_valid never depends combinationally on out_ready.
- Stage 1 (S1), on accept:
  - lz = leading-zero count of in_mant (0..23); lz = 24 for zero.
  - Register the normalized value (in_mant << lz), lz, in_exp and the zero flag.
- Stage 2 (S2), from S1:
  - top = norm[23:8], guard = norm[7], sticky = OR(norm[6:0]).
  - Round up iff guard & (sticky | top[0]).
  - If the increment carries out of 16 bits: out_mant = 0x8000 and carry = 1; otherwise carry = 0.
  - Exponent computed at EXPWRDLEN+2 bits signed: e = in_exp - lz + carry.
- Zero input: out_mant = 0, out_exp = 0, out_zero = 1, unf = ovf = 0, regardless of in_exp.
- Pipeline control:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid | S2_load.
- Timing:
  - Latency: 2 cycles from accept to out_valid when out_ready is held high.
  - Throughput: 1 beat/cycle.
  - Capacity: 2 beats.
- Simultaneous accept and drain in the same cycle keep full throughput. There are no bubbles and no reordering.

Optional Feature:
- Macro: MANT_NORM_SAT_EN.
- Defined:
  - e < 0 → out_exp = 0, out_mant = 0, out_unf = 1.
  - e > 2^EXPWRDLEN-1 → out_exp = all ones, out_mant = 0x8000, out_ovf = 1.
  - Flags are registered alongside out_mant and valid only with out_valid.
- Undefined:
  - out_exp = e modulo 2^EXPWRDLEN (wraps).
  - out_mant is unclamped.
  - out_unf and out_ovf are tied to 0.
  - No saturation logic is synthesized.

Test Plan:
- Basic pass-through: in_mant=0x800000, in_exp=100, out_ready=1 → out_mant=0x8000, out_exp=100, out_valid exactly 2 cycles after accept.
- Maximum shift: in_mant=0x000001, in_exp=50 → out_mant=0x8000, out_exp=27.
- Rounding:
  - 0xFFFF80, exp 10 → round carry: out_mant=0x8000, out_exp=11.
  - 0x800080 → 0x8000 (tie, even kept).
  - 0x800180 → 0x8002 (tie, rounded to even).
  - 0x800081 → 0x8001.
- Zero and underflow:
  - in_mant=0, in_exp=77 → out_zero=1, out_mant=0, out_exp=0.
  - in_mant=0x000100, in_exp=10 (lz=15), with MANT_NORM_SAT_EN → out_exp=0, out_unf=1.
  - Same input without the macro → out_exp=251, out_unf=0.
- Backpressure: offer 6 back-to-back beats with out_ready=0 for 5 cycles → exactly 2 accepted and in_ready=0. Release out_ready → all 6 emerge in order, no loss or duplication, 1/cycle.
- Reset mid-flight: assert rst for 1 cycle with both stages full → out_valid=0 next cycle, no stale beat emerges, in_ready=1 after rst drops.
